// File: rtl/mii_pkg.sv
// Shared MII transmit definitions: FSM state encoding and the fixed nibble
// values driven onto TXD during the preamble and start-of-frame delimiter.
package mii_pkg;
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_SFD  = 3'd2,
      ST_DLO  = 3'd3,
      ST_DHI  = 3'd4,
      ST_ERR  = 3'd5,
      ST_IFG  = 3'd6
   } mii_state_e;

   localparam logic [3:0] MII_PRE_NIBBLE = 4'h5;
   localparam logic [3:0] MII_SFD_HI     = 4'hD;
   localparam int         MII_DEF_IFG    = 24;
endpackage

// File: rtl/mii_tx_if.sv
// Upstream byte stream into the MII transmit framer (valid/ready, last-qualified).
interface mii_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;

   modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
   modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/mii_tx.sv
// MII transmit framer: byte stream in, one nibble per mii_clk out (low nibble first),
// with preamble/SFD prepended, underrun abort via TX_ER, and a fixed inter-frame gap.
module mii_tx
   import mii_pkg::*;
#(
   parameter int PREAMBLE_NIBBLES = 15,
   parameter int IFG_NIBBLES      = MII_DEF_IFG
) (
   input  logic       mii_clk,
   input  logic       reset,
   mii_tx_if.slave    tx,
   output logic [3:0] mii_txd,
   output logic       mii_tx_en,
   output logic       mii_tx_er,
   output logic       busy,
   output logic       underrun
);
   localparam logic [2:0] IDLE = ST_IDLE;
   localparam logic [2:0] PRE  = ST_PRE;
   localparam logic [2:0] SFD  = ST_SFD;
   localparam logic [2:0] DLO  = ST_DLO;
   localparam logic [2:0] DHI  = ST_DHI;
   localparam logic [2:0] ERR  = ST_ERR;
   localparam logic [2:0] IFG  = ST_IFG;

   localparam int MAXN = (PREAMBLE_NIBBLES > IFG_NIBBLES) ? PREAMBLE_NIBBLES : IFG_NIBBLES;
   localparam int CW   = $clog2(MAXN + 1);
   localparam logic [CW-1:0] PRE_LOAD = CW'(PREAMBLE_NIBBLES - 1);
   localparam logic [CW-1:0] IFG_LOAD = CW'(IFG_NIBBLES - 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    byte_q, byte_d;
   logic          last_q, last_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (tx.tx_valid) begin
               state_d = PRE;
               cnt_d   = PRE_LOAD;
            end
         end
         PRE: begin
            if (cnt_q == '0) state_d = SFD;
            else             cnt_d   = cnt_q - CW'(1);
         end
         SFD: begin
            if (tx.tx_valid) begin
               byte_d  = tx.tx_data;
               last_d  = tx.tx_last;
               state_d = DLO;
            end else begin
               state_d = ERR;
            end
         end
         DLO: state_d = DHI;
         DHI: begin
            // Final byte goes straight to the gap; otherwise the next byte must
            // already be waiting, since the wire cannot stall mid-frame.
            if (last_q) begin
               state_d = IFG;
               cnt_d   = IFG_LOAD;
            end else if (tx.tx_valid) begin
               byte_d  = tx.tx_data;
               last_d  = tx.tx_last;
               state_d = DLO;
            end else begin
               state_d = ERR;
            end
         end
         ERR: begin
            state_d = IFG;
            cnt_d   = IFG_LOAD;
         end
         IFG: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mii_clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         byte_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
      end
   end

   // Every output is a pure decode of registered state; tx_valid never reaches tx_ready.
   assign tx.tx_ready = (state_q == SFD) || ((state_q == DHI) && !last_q);

   always_comb begin
      mii_txd   = 4'h0;
      mii_tx_en = 1'b0;
      case (state_q)
         PRE: begin mii_txd = MII_PRE_NIBBLE; mii_tx_en = 1'b1; end
         SFD: begin mii_txd = MII_SFD_HI;     mii_tx_en = 1'b1; end
         DLO: begin mii_txd = byte_q[3:0];    mii_tx_en = 1'b1; end
         DHI: begin mii_txd = byte_q[7:4];    mii_tx_en = 1'b1; end
         ERR: mii_tx_en = 1'b1;
         default: ;
      endcase
   end

   assign mii_tx_er = (state_q == ERR);
   assign underrun  = (state_q == ERR);
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mii_tx.sv
// Directed bench for mii_tx: scoreboard of expected {tx_er,txd} nibbles plus cycle-exact checks.
module tb_mii_tx;
   logic       mii_clk;
   logic       reset;
   logic [3:0] txd, b_txd;
   logic       tx_en, tx_er, busy, under;
   logic       b_en, b_er, b_busy, b_under;

   mii_tx_if a_if ();
   mii_tx_if b_if ();

   mii_tx dut (
      .mii_clk(mii_clk), .reset(reset), .tx(a_if.slave),
      .mii_txd(txd), .mii_tx_en(tx_en), .mii_tx_er(tx_er),
      .busy(busy), .underrun(under)
   );

   mii_tx #(.PREAMBLE_NIBBLES(3), .IFG_NIBBLES(2)) dut2 (
      .mii_clk(mii_clk), .reset(reset), .tx(b_if.slave),
      .mii_txd(b_txd), .mii_tx_en(b_en), .mii_tx_er(b_er),
      .busy(b_busy), .underrun(b_under)
   );

   int total = 0;
   int bad   = 0;
   logic [4:0] q1[$];
   logic [4:0] q2[$];
   logic [7:0] fb[8];

   initial begin
      mii_clk = 1'b0;
      forever #5 mii_clk = ~mii_clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge mii_clk);
      #1;
   endtask

   // Wire-side scoreboards: every TX_EN nibble is matched against the queue.
   always @(negedge mii_clk) begin
      if (tx_en === 1'b1) begin
         if (q1.size() == 0) check("sb1_extra", q1.size(), 1);
         else check("sb1_nib", {tx_er, txd}, q1.pop_front());
      end
      if (b_en === 1'b1) begin
         if (q2.size() == 0) check("sb2_extra", q2.size(), 1);
         else check("sb2_nib", {b_er, b_txd}, q2.pop_front());
      end
   end

   task automatic start_frame(input int n, input bit uflow);
      for (int c = 0; c < 15; c++) q1.push_back({1'b0, 4'h5});
      q1.push_back({1'b0, 4'hD});
      for (int i = 0; i < n; i++) begin
         q1.push_back({1'b0, fb[i][3:0]});
         q1.push_back({1'b0, fb[i][7:4]});
      end
      if (uflow) q1.push_back(5'h10);
      a_if.tx_valid = 1'b1;
      a_if.tx_data  = fb[0];
      a_if.tx_last  = (n == 1) && !uflow;
      check("idle_rdy", a_if.tx_ready, 0);
   endtask

   task automatic frame_body(input int n, input bit keep, input int pre, input bit uflow);
      for (int c = 0; c < pre; c++) begin
         tick();
         check("pre_en", tx_en, 1);
         check("pre_rdy", a_if.tx_ready, 0);
      end
      tick();
      check("sfd_rdy", a_if.tx_ready, 1);
      for (int i = 0; i < n; i++) begin
         tick();
         if (i + 1 < n) begin
            a_if.tx_data = fb[i+1];
            a_if.tx_last = (i + 1 == n - 1) && !uflow;
         end else if (!keep) begin
            a_if.tx_valid = 1'b0;
         end
         check("dlo_rdy", a_if.tx_ready, 0);
         tick();
         check("dhi_rdy", a_if.tx_ready, ((i != n - 1) || uflow) ? 1 : 0);
      end
   endtask

   task automatic wait_ifg(input int exp_n);
      int n;
      n = 0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (busy && !tx_en) begin
            n++;
            check("ifg_txd", {tx_er, txd, under, a_if.tx_ready}, 0);
         end else begin
            break;
         end
      end
      check("ifg_len", n, exp_n);
      check("idle_after_ifg", {busy, tx_en}, 0);
   endtask

   initial begin
      int gap;
      reset = 1'b1;
      a_if.tx_valid = 1'b0; a_if.tx_data = 8'h00; a_if.tx_last = 1'b0;
      b_if.tx_valid = 1'b0; b_if.tx_data = 8'h00; b_if.tx_last = 1'b0;
      tick();
      tick();
      check("rst_out", {txd, tx_en, tx_er, busy, under, a_if.tx_ready}, 0);
      check("rst_out2", {b_txd, b_en, b_er, b_busy, b_under, b_if.tx_ready}, 0);
      reset = 1'b0;
      tick();
      check("idle_out", {txd, tx_en, busy}, 0);

      // Single byte frame
      fb[0] = 8'hA5;
      start_frame(1, 0);
      frame_body(1, 0, 15, 0);
      wait_ifg(24);

      // Three bytes back to back
      fb[0] = 8'h01; fb[1] = 8'h23; fb[2] = 8'hFE;
      start_frame(3, 0);
      frame_body(3, 0, 15, 0);
      wait_ifg(24);

      // Underrun after first byte
      fb[0] = 8'h55;
      start_frame(1, 1);
      frame_body(1, 0, 15, 1);
      tick();
      check("err_flags", {tx_en, tx_er, txd, under}, 7'b1_1_0000_1);
      wait_ifg(24);

      // Two frames with tx_valid held through the gap
      fb[0] = 8'h12; fb[1] = 8'h34;
      start_frame(2, 0);
      frame_body(2, 1, 15, 0);
      fb[0] = 8'h9A;
      a_if.tx_data = 8'h9A;
      a_if.tx_last = 1'b1;
      for (int c = 0; c < 15; c++) q1.push_back({1'b0, 4'h5});
      q1.push_back({1'b0, 4'hD});
      q1.push_back({1'b0, 4'hA});
      q1.push_back({1'b0, 4'h9});
      gap = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         gap++;
         if (tx_en) break;
      end
      check("b2b_gap", gap, 26);
      frame_body(1, 0, 14, 0);
      wait_ifg(24);

      // Reset during the low nibble of the second byte
      fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
      start_frame(3, 0);
      for (int c = 0; c < 16; c++) tick();
      check("rst_sfd", a_if.tx_ready, 1);
      tick();
      a_if.tx_data = fb[1];
      tick();
      tick();
      check("rst_dlo_en", tx_en, 1);
      reset = 1'b1;
      tick();
      check("rst_mid", {txd, tx_en, tx_er, busy, a_if.tx_ready}, 0);
      reset = 1'b0;
      check("rst_q_left", q1.size(), 3);
      q1.delete();
      fb[0] = 8'h77;
      start_frame(1, 0);
      frame_body(1, 0, 15, 0);
      wait_ifg(24);

      // Short preamble / short gap instance
      q2.push_back({1'b0, 4'h5}); q2.push_back({1'b0, 4'h5}); q2.push_back({1'b0, 4'h5});
      q2.push_back({1'b0, 4'hD}); q2.push_back({1'b0, 4'hC}); q2.push_back({1'b0, 4'h3});
      b_if.tx_valid = 1'b1; b_if.tx_data = 8'h3C; b_if.tx_last = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("p2_pre_en", b_en, 1);
      end
      tick();
      check("p2_sfd_rdy", b_if.tx_ready, 1);
      tick();
      b_if.tx_valid = 1'b0;
      tick();
      check("p2_dhi_rdy", b_if.tx_ready, 0);
      gap = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (b_busy && !b_en) gap++;
         else break;
      end
      check("p2_ifg_len", gap, 2);
      check("p2_idle", {b_busy, b_en}, 0);

      tick();
      check("sb1_empty", q1.size(), 0);
      check("sb2_empty", q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mii_tx.md
Name: mii_tx

Overview:
MII transmit framer. It accepts bytes from an upstream valid/ready stream and emits one 4-bit nibble per mii_clk, low nibble first. It prepends the preamble and SFD, and after the frame enforces the inter-frame gap. It is the transmit counterpart of the nibble-to-byte MII receive path and sits between the MAC byte stream and the PHY TXD/TX_EN pins.

Parameters:
PREAMBLE_NIBBLES, 15, count of 0x5 nibbles driven before the SFD high nibble. 15 gives 7 preamble bytes plus the SFD low nibble.
IFG_NIBBLES, 24, idle nibble times after each frame (96 bit times).

Ports:
mii_clk  in  1  transmit clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high.
tx_valid  in  1  upstream byte valid; frame start request when idle.
tx_data  in  8  upstream byte.
tx_last  in  1  qualifies tx_data as final byte of frame.
tx_ready  out  1  byte on tx_data is consumed at this edge when tx_valid=1.
mii_txd  out  4  MII TXD[3:0].
mii_tx_en  out  1  MII TX_EN.
mii_tx_er  out  1  MII TX_ER.
busy  out  1  high whenever state != IDLE.
underrun  out  1  one-cycle pulse on frame abort due to missing data.

Behaviour:
- Reset is applied at the next mii_clk edge and overrides everything: state=IDLE, counters=0, tx_ready=0, mii_txd=0, mii_tx_en=0, mii_tx_er=0, busy=0, underrun=0.
- Reset during a frame truncates it immediately. No IFG is inserted and no tx_er is driven.
- All outputs are registered or decoded from registered state only. tx_ready is a combinational decode of state and a registered last flag, with no path from tx_valid.
- States: IDLE, PRE, SFD, DLO, DHI, ERR, IFG.
- IDLE: mii_tx_en=0, mii_txd=0. If tx_valid=1, go to PRE and load cnt=PREAMBLE_NIBBLES-1. tx_ready stays 0, so no byte is consumed.
- PRE: mii_tx_en=1, mii_txd=4'h5. Decrement cnt; when cnt=0, go to SFD.
- SFD: mii_tx_en=1, mii_txd=4'hD, tx_ready=1.
  - If tx_valid=1: latch tx_data into byte_q and tx_last into last_q, then go to DLO.
  - If tx_valid=0: go to ERR.
- DLO: mii_tx_en=1, mii_txd=byte_q[3:0], then go to DHI.
- DHI: mii_tx_en=1, mii_txd=byte_q[7:4], tx_ready=!last_q.
  - If last_q=1: go to IFG with cnt=IFG_NIBBLES-1.
  - Else if tx_valid=1: latch the byte and last flag, then go to DLO. This gives back-to-back bytes with no gap nibbles.
  - Else: go to ERR.
- ERR: mii_tx_en=1, mii_tx_er=1, mii_txd=0 for exactly one nibble. underrun=1 in this cycle. Then go to IFG with cnt=IFG_NIBBLES-1.
- IFG: mii_tx_en=0, mii_txd=0, tx_ready=0. tx_valid is ignored. Decrement cnt; when cnt=0, go to IDLE.
  - IFG therefore lasts exactly IFG_NIBBLES cycles.
  - The next frame's first preamble nibble appears no earlier than IFG_NIBBLES+2 cycles after the last data nibble.
- Timing, with frame request seen in IDLE at cycle 0:
  - preamble nibbles in cycles 1..PREAMBLE_NIBBLES;
  - SFD 0xD in cycle PREAMBLE_NIBBLES+1, where the first byte is consumed;
  - first low nibble in the following cycle.
- Upstream contract: once tx_valid is raised for a frame, it must be held until the tx_last byte is consumed. Dropping it at any tx_ready cycle is an underrun, handled as above.
- A single-byte frame (tx_last=1 on the first byte) is legal.
- Frame length is unbounded; no byte counter is kept.
- cnt width: $clog2(max(PREAMBLE_NIBBLES, IFG_NIBBLES)+1). Both parameters must be >= 1.

Decomposition:
- Shared package mii_pkg:
  - state enum (IDLE, PRE, SFD, DLO, DHI, ERR, IFG);
  - localparams MII_PRE_NIBBLE=4'h5, MII_SFD_HI=4'hD, MII_DEF_IFG=24.
- Single flat module; no sub-module is warranted.

Test Plan:
- Frame of one byte 0xA5 with tx_last=1, tx_valid rising at cycle 0:
  - cycles 1..15: txd=5, tx_en=1;
  - cycle 16: txd=D, tx_ready=1;
  - cycle 17: txd=5; cycle 18: txd=A;
  - then 24 cycles with tx_en=0, then busy=0.
- Frame 0x01,0x23,0xFE (last on 0xFE) with tx_valid held:
  - after SFD, nibbles are 1,0,3,2,E,F with tx_en=1 and no gaps;
  - tx_ready is high on SFD and the first two DHI cycles only.
- Underrun: after 0x55 is consumed (not last), drop tx_valid:
  - nibbles 5,5, then one nibble with tx_en=1, tx_er=1, txd=0, and underrun pulses once;
  - then 24 IFG cycles.
- Two back-to-back frames with tx_valid asserted throughout the IFG: the second preamble starts exactly 26 cycles after the first frame's last data nibble.
- Assert reset for one cycle during the DLO of byte 2: the next cycle shows tx_en=0, txd=0, busy=0, with no IFG wait.
- Parameter override PREAMBLE_NIBBLES=3, IFG_NIBBLES=2, byte 0x3C: nibble sequence is 5,5,5,D,C,3, then exactly 2 idle cycles.
